// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the round-robin BCD converter arbiter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  localparam int BCD_W   = 16;
  localparam int BCD_MAX = 9999;
  localparam logic [BCD_W-1:0] BCD_SAT = 16'h9999;
  localparam logic [BCD_W-1:0] BCD_ERR = 16'hEEEE;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_pick
  import bcd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NREQ);
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one binary-to-BCD converter among NREQ requesters with round-robin grant.
// Optional watchdog abort in WAIT is enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_convert_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int VAL_W       = 14,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*VAL_W-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic                    cvt_start,
  output logic [VAL_W-1:0]        cvt_value,
  input  logic                    cvt_done,
  input  logic [BCD_W-1:0]        cvt_bcd,
  output logic [BCD_W-1:0]        bcd_out,
  output logic                    bcd_valid,
  output logic                    bcd_ovf,
  output logic                    err
);

  localparam int IDX_W = idx_width(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bcd_convert_arbiter: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("bcd_convert_arbiter: TIMEOUT_CYC must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, pick_idx, ptr_next;
  logic [NREQ-1:0]  pick_grant, owner_q;
  logic [VAL_W-1:0] pick_val;
  logic             any_req, out_of_range;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign any_req      = |req;
  assign pick_val     = req_data[pick_idx*VAL_W +: VAL_W];
  assign out_of_range = 32'(pick_val) > BCD_MAX;
  assign ptr_next     = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tcnt_q;
  logic             err_q;
  logic             timeout;

  // Fires on the last permitted WAIT cycle so the abort follows exactly TIMEOUT_CYC WAIT cycles.
  assign timeout = (tcnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = out_of_range ? DELIVER : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (cvt_done) state_d = DELIVER;
`ifdef BCD_ARB_TIMEOUT_EN
        else if (timeout) state_d = DELIVER;
`endif
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand, owner and result registers; out-of-range operands bypass the converter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      cvt_value <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            cvt_value <= pick_val;
            owner_q   <= pick_grant;
            ptr_q     <= ptr_next;
            ovf_q     <= out_of_range;
            if (out_of_range) bcd_q <= BCD_SAT;
          end
        end
        WAIT: begin
          if (cvt_done) bcd_q <= cvt_bcd;
`ifdef BCD_ARB_TIMEOUT_EN
          else if (timeout) bcd_q <= BCD_ERR;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (any_req) err_q <= 1'b0;
        ISSUE: tcnt_q <= '0;
        WAIT: begin
          if (!cvt_done) begin
            if (timeout) err_q <= 1'b1;
            else         tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err = bcd_valid & err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign cvt_start = (state_q == ISSUE);
  assign bcd_valid = (state_q == DELIVER);
  assign ack       = bcd_valid ? owner_q : '0;
  assign bcd_out   = bcd_q;
  assign bcd_ovf   = bcd_valid & ovf_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter with a fixed-latency converter model.
// Define BCD_ARB_TIMEOUT_EN to also exercise the watchdog abort.
module tb_bcd_convert_arbiter;

  localparam int NREQ    = 4;
  localparam int VAL_W   = 14;
  localparam int CVT_LAT = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*VAL_W-1:0] req_data = '0;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic                  cvt_start;
  logic [VAL_W-1:0]      cvt_value;
  logic                  cvt_done = 1'b0;
  logic [15:0]           cvt_bcd = '0;
  logic [15:0]           bcd_out;
  logic                  bcd_valid;
  logic                  bcd_ovf;
  logic                  err;

  int checks   = 0;
  int failures = 0;
  bit cvt_en   = 1'b1;
  int cvt_cnt  = 0;

  always #5 clk = ~clk;

  bcd_convert_arbiter #(
    .NREQ        (NREQ),
    .VAL_W       (VAL_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .busy      (busy),
    .cvt_start (cvt_start),
    .cvt_value (cvt_value),
    .cvt_done  (cvt_done),
    .cvt_bcd   (cvt_bcd),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ovf   (bcd_ovf),
    .err       (err)
  );

  function automatic logic [15:0] to_bcd(input logic [VAL_W-1:0] v);
    int n;
    n = int'(v);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Converter model: done pulses CVT_LAT cycles after start is seen, unless disabled.
  always @(negedge clk) begin
    if (!rst) begin
      cvt_cnt  = 0;
      cvt_done = 1'b0;
    end else begin
      cvt_done = 1'b0;
      if (cvt_start) begin
        cvt_cnt = CVT_LAT;
      end else if (cvt_cnt > 0) begin
        cvt_cnt = cvt_cnt - 1;
        if (cvt_cnt == 0 && cvt_en) begin
          cvt_done = 1'b1;
          cvt_bcd  = to_bcd(cvt_value);
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic set_data(input int i, input logic [VAL_W-1:0] v);
    req_data[i*VAL_W +: VAL_W] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Bounded wait for the next ack, counting start pulses seen on the way.
  task automatic wait_ack(input string tag, output logic [NREQ-1:0] a, output int starts, output int cycles);
    a      = '0;
    starts = 0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cycles++;
      if (cvt_start) starts++;
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
    check_output({tag, "_seen"}, 32'(a != '0), 32'd1);
  endtask

  logic [NREQ-1:0] got_ack;
  int              starts;
  int              cycles;
  logic [15:0]     exp_rr [4] = '{16'h0011, 16'h0222, 16'h3333, 16'h9999};

  initial begin
    $display("[TB] start");

    // Reset values
    @(negedge clk);
    check_output("rst_ack",   32'(ack), 32'd0);
    check_output("rst_busy",  32'(busy), 32'd0);
    check_output("rst_flags", 32'({cvt_start, bcd_valid, bcd_ovf, err}), 32'd0);
    check_output("rst_value", 32'(cvt_value), 32'd0);
    check_output("rst_bcd",   32'(bcd_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single request, value 1234
    set_data(0, 14'd1234);
    req = 4'b0001;
    wait_ack("t1", got_ack, starts, cycles);
    check_output("t1_ack",    32'(got_ack), 32'h1);
    check_output("t1_starts", 32'(starts), 32'd1);
    check_output("t1_bcd",    32'(bcd_out), 32'h1234);
    check_output("t1_valid",  32'({bcd_valid, bcd_ovf, err}), 32'b100);
    req = '0;
    @(negedge clk);
    check_output("t1_ack_pulse", 32'(ack), 32'd0);

    // All four requesting continuously: order 0,1,2,3,0
    apply_reset();
    set_data(0, 14'd11);
    set_data(1, 14'd222);
    set_data(2, 14'd3333);
    set_data(3, 14'd9999);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack($sformatf("t2_%0d", k), got_ack, starts, cycles);
      check_output($sformatf("t2_ack_%0d", k),    32'(got_ack), 32'(1 << (k % 4)));
      check_output($sformatf("t2_starts_%0d", k), 32'(starts), 32'd1);
      check_output($sformatf("t2_bcd_%0d", k),    32'({bcd_ovf, bcd_out}), 32'(exp_rr[k % 4]));
    end
    req = '0;

    // Out-of-range operand bypasses the converter
    @(negedge clk);
    set_data(2, 14'd10000);
    req = 4'b0100;
    wait_ack("t3", got_ack, starts, cycles);
    check_output("t3_ack",    32'(got_ack), 32'h4);
    check_output("t3_starts", 32'(starts), 32'd0);
    check_output("t3_cycles", 32'(cycles), 32'd1);
    check_output("t3_bcd",    32'(bcd_out), 32'h9999);
    check_output("t3_ovf",    32'(bcd_ovf), 32'd1);
    req = '0;
    @(negedge clk);
    check_output("t3_idle", 32'({busy, ack}), 32'd0);

    // Request and operand change during WAIT are ignored
    set_data(1, 14'd567);
    req = 4'b0010;
    @(negedge clk);
    check_output("t4_start", 32'(cvt_start), 32'd1);
    @(negedge clk);
    check_output("t4_wait_value", 32'({busy, cvt_value}), 32'({1'b1, 14'd567}));
    req = '0;
    set_data(1, 14'd8888);
    wait_ack("t4", got_ack, starts, cycles);
    check_output("t4_ack",   32'(got_ack), 32'h2);
    check_output("t4_bcd",   32'(bcd_out), 32'h0567);
    check_output("t4_value", 32'(cvt_value), 32'd567);

    // Asynchronous reset during WAIT
    @(negedge clk);
    set_data(3, 14'd4321);
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check_output("t5_in_wait", 32'({busy, cvt_start}), 32'b10);
    req = '0;
    #2 rst = 1'b0;
    #1;
    check_output("t5_rst_flags", 32'({busy, cvt_start, bcd_valid, ack}), 32'd0);
    check_output("t5_rst_value", 32'(cvt_value), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_data(0, 14'd55);
    set_data(3, 14'd66);
    req = 4'b1001;
    wait_ack("t5", got_ack, starts, cycles);
    check_output("t5_ack", 32'(got_ack), 32'h1);
    check_output("t5_bcd", 32'(bcd_out), 32'h0055);
    req = '0;

`ifdef BCD_ARB_TIMEOUT_EN
    // Converter never completes: abort after 8 WAIT cycles
    apply_reset();
    cvt_en = 1'b0;
    set_data(0, 14'd100);
    req = 4'b0001;
    wait_ack("t6", got_ack, starts, cycles);
    check_output("t6_ack",    32'(got_ack), 32'h1);
    check_output("t6_cycles", 32'(cycles), 32'd10);
    check_output("t6_bcd",    32'(bcd_out), 32'hEEEE);
    check_output("t6_err",    32'({err, bcd_ovf}), 32'b10);
    req = '0;
    cvt_en = 1'b1;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
